// File: rtl/wb_trace_uart_if.sv
// Write-back event bus from the CPU core into the trace UART.
// The core drives the strobe, destination index and value every clk.
interface wb_trace_uart_if;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (output wb_valid, output wb_rd, output wb_data);
   modport slave  (input  wb_valid, input  wb_rd, input  wb_data);
endinterface

// File: rtl/wb_trace_uart.sv
// Register write-back tracer: captures {rd, data} events into a small FIFO
// and sends each one as a 6-byte UART 8N1 frame:
// A5, rd, data[31:24], data[23:16], data[15:8], data[7:0].
module wb_trace_uart #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        resetn,
   wb_trace_uart_if.slave              wb,
   output logic                        txd,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]     bit_idx;
   logic [2:0]     byte_idx;
   logic [47:0]    frame;
   logic [7:0]     tx_byte;

   logic [36:0]    mem [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic [36:0]    head;

   logic empty;
   logic full;
   logic push_req;
   logic push;
   logic pop;
   logic bit_end;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push_req = wb.wb_valid && (wb.wb_rd != 5'd0);
   // The transmitter takes the head entry whenever it is idle.
   assign pop      = (state == IDLE) && !empty;
   // A pop on the same edge frees a slot, so a push into a full FIFO is legal then.
   assign push     = push_req && (!full || pop);
   assign head     = mem[rd_ptr[PTR_W-1:0]];

   assign fifo_level = wr_ptr - rd_ptr;
   assign busy       = (state != IDLE) || !empty;
   assign tx_byte    = frame[47:40];
   assign bit_end    = (cnt == CNT_LAST);

   // FIFO storage write.
   // NOTE: the entry array carries no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= {wb.wb_rd, wb.wb_data};
   end

   // FIFO pointers and the sticky overflow flag.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push_req && full && !pop) overflow <= 1'b1;
      end
   end

   // UART transmit FSM; txd is driven straight from this register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         txd      <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         frame    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  frame    <= {8'hA5, 3'b000, head};
                  txd      <= 1'b0;
                  cnt      <= '0;
                  byte_idx <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  txd     <= tx_byte[0];
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     txd     <= tx_byte[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (byte_idx < 3'd5) begin
                     byte_idx <= byte_idx + 1'b1;
                     frame    <= {frame[39:0], 8'h00};
                     txd      <= 1'b0;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
